// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: HH:MM:SS timekeeper with key-driven set mode.
// Emits BCD digits and a per-digit blink mask for the display scanner.
module clock_time_ctrl #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BLINK_HALF = 12_500_000
) (
    input  logic       CLK_50M,
    input  logic       RST_N,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [3:0] hours2_data,
    output logic [3:0] hours1_data,
    output logic [3:0] minutes2_data,
    output logic [3:0] minutes1_data,
    output logic [3:0] seconds2_data,
    output logic [3:0] seconds1_data,
    output logic [5:0] blink_mask,
    output logic [1:0] mode
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] SET_HOUR = 2'd1;
    localparam logic [1:0] SET_MIN  = 2'd2;
    localparam logic [1:0] SET_SEC  = 2'd3;

    localparam int TW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_FREQ - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [7:0]    hh;
    logic [7:0]    mm;
    logic [7:0]    ss;
    logic [TW-1:0] tick_cnt;
    logic          sec_tick;
    logic          in_set;
    logic          inc_ok;
    logic [1:0]    mode_n;
    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] blink_cnt_n;
    logic          phase;
    logic          phase_n;
    logic [5:0]    mask_n;

    // Two-digit BCD increment that wraps to 00 after `last`.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] last);
        logic [7:0] r;
        if (v == last)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    assign in_set   = (mode != RUN);
    assign sec_tick = !in_set && (tick_cnt == TICK_LAST);
    // A mode change swallows a coincident increment.
    assign inc_ok   = in_set && key_inc && !key_mode;
    assign mode_n   = key_mode ? mode + 2'd1 : mode;

    assign hours2_data   = hh[7:4];
    assign hours1_data   = hh[3:0];
    assign minutes2_data = mm[7:4];
    assign minutes1_data = mm[3:0];
    assign seconds2_data = ss[7:4];
    assign seconds1_data = ss[3:0];

    // Second prescaler: free-runs only in RUN, parked at 0 while setting.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N)
            tick_cnt <= '0;
        else if (in_set || sec_tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end

    // Mode sequencer: RUN -> HOUR -> MIN -> SEC -> RUN on each mode key.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N)
            mode <= RUN;
        else
            mode <= mode_n;
    end

    // Time registers: carry chain on tick, single-field edit in set mode.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            hh <= 8'h00;
            mm <= 8'h00;
            ss <= 8'h00;
        end else if (sec_tick) begin
            ss <= bcd_inc(ss, 8'h59);
            if (ss == 8'h59) begin
                mm <= bcd_inc(mm, 8'h59);
                if (mm == 8'h59)
                    hh <= bcd_inc(hh, 8'h23);
            end
        end else if (inc_ok) begin
            case (mode)
                SET_HOUR: hh <= bcd_inc(hh, 8'h23);
                SET_MIN:  mm <= bcd_inc(mm, 8'h59);
                SET_SEC:  ss <= bcd_inc(ss, 8'h59);
                default:  ;
            endcase
        end
    end

    // Blink timing; restarts on mode change or edit so the field shows at once.
    always_comb begin
        blink_cnt_n = blink_cnt;
        phase_n     = phase;
        mask_n      = 6'b000000;
        if (key_mode || !in_set || inc_ok) begin
            blink_cnt_n = '0;
            phase_n     = 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_n = '0;
            phase_n     = !phase;
        end else begin
            blink_cnt_n = blink_cnt + BW'(1);
        end
        if (phase_n) begin
            case (mode_n)
                SET_HOUR: mask_n = 6'b000011;
                SET_MIN:  mask_n = 6'b001100;
                SET_SEC:  mask_n = 6'b110000;
                default:  mask_n = 6'b000000;
            endcase
        end
    end

    // Blink state and registered mask, aligned with the new mode.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            blink_cnt  <= '0;
            phase      <= 1'b0;
            blink_mask <= 6'b000000;
        end else begin
            blink_cnt  <= blink_cnt_n;
            phase      <= phase_n;
            blink_mask <= mask_n;
        end
    end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl: directed vector table plus corner-case sequences
// for the clock_time_ctrl timekeeper, using CLK_FREQ=10, BLINK_HALF=3.
module tb_clock_time_ctrl;

    logic       CLK_50M;
    logic       RST_N;
    logic       key_mode;
    logic       key_inc;
    logic [3:0] hours2_data;
    logic [3:0] hours1_data;
    logic [3:0] minutes2_data;
    logic [3:0] minutes1_data;
    logic [3:0] seconds2_data;
    logic [3:0] seconds1_data;
    logic [5:0] blink_mask;
    logic [1:0] mode;

    int total;
    int passed;

    typedef struct {
        logic        km;
        logic        ki;
        logic [23:0] t;
        logic [1:0]  md;
        logic [5:0]  mk;
    } vec_t;

    vec_t tbl [32];

    clock_time_ctrl #(
        .CLK_FREQ  (10),
        .BLINK_HALF(3)
    ) dut (
        .CLK_50M      (CLK_50M),
        .RST_N        (RST_N),
        .key_mode     (key_mode),
        .key_inc      (key_inc),
        .hours2_data  (hours2_data),
        .hours1_data  (hours1_data),
        .minutes2_data(minutes2_data),
        .minutes1_data(minutes1_data),
        .seconds2_data(seconds2_data),
        .seconds1_data(seconds1_data),
        .blink_mask   (blink_mask),
        .mode         (mode)
    );

    initial CLK_50M = 1'b0;
    always #5 CLK_50M = ~CLK_50M;

    // Compare time/mode/mask against expected values.
    task automatic chk(input string name, input logic [23:0] t,
                       input logic [1:0] md, input logic [5:0] mk);
        logic [23:0] at;
        at = {hours2_data, hours1_data, minutes2_data,
              minutes1_data, seconds2_data, seconds1_data};
        total++;
        if (at === t && mode === md && blink_mask === mk)
            passed++;
        else
            $display("FAIL %s: got time %h mode %0d mask %b, want time %h mode %0d mask %b",
                     name, at, mode, blink_mask, t, md, mk);
    endtask

    // One clock with the given key levels, sampled 1 ns after the edge.
    task automatic cyc(input logic km, input logic ki);
        @(negedge CLK_50M);
        key_mode = km;
        key_inc  = ki;
        @(posedge CLK_50M);
        #1;
    endtask

    task automatic rel();
        @(negedge CLK_50M);
        RST_N    = 1'b1;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        @(posedge CLK_50M);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK_50M);
        key_mode = 1'b0;
        key_inc  = 1'b0;
        RST_N    = 1'b0;
        #2;
    endtask

    task automatic sv(input int i, input logic km, input logic ki,
                      input logic [23:0] t, input logic [1:0] md,
                      input logic [5:0] mk);
        tbl[i] = '{km, ki, t, md, mk};
    endtask

    initial begin
        total    = 0;
        passed   = 0;
        RST_N    = 1'b0;
        key_mode = 1'b0;
        key_inc  = 1'b0;

        // Vector table, applied right after a reset release.
        sv(0,  1, 0, 24'h000000, 1, 6'h00);
        sv(1,  0, 1, 24'h010000, 1, 6'h00);
        sv(2,  0, 0, 24'h010000, 1, 6'h00);
        sv(3,  0, 0, 24'h010000, 1, 6'h00);
        sv(4,  0, 0, 24'h010000, 1, 6'b000011);
        sv(5,  0, 1, 24'h020000, 1, 6'h00);
        sv(6,  1, 1, 24'h020000, 2, 6'h00);
        sv(7,  0, 1, 24'h020100, 2, 6'h00);
        sv(8,  1, 0, 24'h020100, 3, 6'h00);
        sv(9,  0, 0, 24'h020100, 3, 6'h00);
        sv(10, 0, 0, 24'h020100, 3, 6'h00);
        sv(11, 0, 0, 24'h020100, 3, 6'b110000);
        sv(12, 0, 0, 24'h020100, 3, 6'b110000);
        sv(13, 0, 0, 24'h020100, 3, 6'b110000);
        sv(14, 0, 0, 24'h020100, 3, 6'h00);
        sv(15, 0, 0, 24'h020100, 3, 6'h00);
        sv(16, 0, 0, 24'h020100, 3, 6'h00);
        sv(17, 0, 0, 24'h020100, 3, 6'b110000);
        sv(18, 0, 0, 24'h020100, 3, 6'b110000);
        sv(19, 0, 0, 24'h020100, 3, 6'b110000);
        sv(20, 0, 1, 24'h020101, 3, 6'h00);
        sv(21, 1, 0, 24'h020101, 0, 6'h00);
        for (int i = 22; i <= 30; i++)
            sv(i, 0, (i == 23), 24'h020101, 0, 6'h00);
        sv(31, 0, 0, 24'h020102, 0, 6'h00);

        // Reset state and free-running seconds.
        #12;
        chk("reset", 24'h000000, 0, 6'h00);
        rel();
        repeat (8) cyc(0, 0);
        chk("edge9", 24'h000000, 0, 6'h00);
        cyc(0, 0);
        chk("edge10", 24'h000001, 0, 6'h00);
        repeat (9) cyc(0, 0);
        chk("edge19", 24'h000001, 0, 6'h00);
        cyc(0, 0);
        chk("edge20", 24'h000002, 0, 6'h00);
        repeat (5) cyc(0, 0);
        chk("edge25", 24'h000002, 0, 6'h00);

        // Table-driven vectors.
        do_reset();
        rel();
        for (int i = 0; i < 32; i++) begin
            cyc(tbl[i].km, tbl[i].ki);
            chk($sformatf("vec%0d", i), tbl[i].t, tbl[i].md, tbl[i].mk);
        end

        // Preload 23:59:58 and roll over midnight.
        do_reset();
        rel();
        cyc(1, 0);
        repeat (23) cyc(0, 1);
        chk("set_h23", 24'h230000, 1, 6'h00);
        cyc(1, 0);
        repeat (59) cyc(0, 1);
        cyc(1, 0);
        repeat (58) cyc(0, 1);
        chk("preload", 24'h235958, 3, 6'h00);
        cyc(1, 0);
        chk("back_run", 24'h235958, 0, 6'h00);
        repeat (9) cyc(0, 0);
        chk("pre_tick", 24'h235958, 0, 6'h00);
        cyc(0, 0);
        chk("t235959", 24'h235959, 0, 6'h00);
        repeat (10) cyc(0, 0);
        chk("midnight", 24'h000000, 0, 6'h00);

        // Field wraps in set mode without carry.
        cyc(1, 0);
        repeat (23) cyc(0, 1);
        cyc(1, 0);
        repeat (59) cyc(0, 1);
        chk("m59", 24'h235900, 2, 6'h00);
        cyc(0, 1);
        chk("m_wrap", 24'h230000, 2, 6'h00);
        cyc(1, 0);
        cyc(1, 0);
        cyc(1, 0);
        chk("h23_again", 24'h230000, 1, 6'h00);
        cyc(0, 1);
        chk("h_wrap", 24'h000000, 1, 6'h00);

        // Asynchronous reset mid-count in SET_MIN at 12:34:56.
        do_reset();
        rel();
        cyc(1, 0);
        repeat (12) cyc(0, 1);
        cyc(1, 0);
        repeat (34) cyc(0, 1);
        cyc(1, 0);
        repeat (56) cyc(0, 1);
        cyc(1, 0);
        cyc(1, 0);
        cyc(1, 0);
        repeat (3) cyc(0, 0);
        chk("pre_rst", 24'h123456, 2, 6'b001100);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_rst", 24'h000000, 0, 6'h00);
        rel();
        repeat (8) cyc(0, 0);
        chk("resume9", 24'h000000, 0, 6'h00);
        cyc(0, 0);
        chk("resume10", 24'h000001, 0, 6'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
